// File: rtl/dmem_lsu.sv
// -----------------------------------------------------------------------------
// dmem_lsu - load/store unit for the single-cycle RISC-V datapath.
//
// Drives every access to a word-addressed data memory that has a combinational
// read port and a write port committing on the rising clock edge. One load or
// store is accepted per handshake. Loads return sign/zero-extended data, byte
// and halfword stores are done as read-modify-write, and misaligned or
// out-of-range requests are answered with resp_err without touching memory.
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  high only in IDLE
//   req_we      in   1 = store, 0 = load
//   req_addr    in   byte address [DATA_W]
//   req_wdata   in   store data (low byte/half used for SB/SH) [DATA_W]
//   req_funct3  in   RISC-V width code
//   resp_valid  out  one-cycle completion pulse
//   resp_rdata  out  extended load data, 0 for stores and errors [DATA_W]
//   resp_err    out  request rejected (valid with resp_valid)
//   mem_we      out  memory write enable
//   mem_addr    out  word index (byte address >> 2) [DATA_W]
//   mem_wdata   out  word to write [DATA_W]
//   mem_rdata   in   combinational read data for mem_addr [DATA_W]
// -----------------------------------------------------------------------------
module dmem_lsu #(
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [2:0]        req_funct3,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    state_t            state;
    logic [DATA_W-1:0] addr_q;
    logic [2:0]        funct3_q;
    logic [DATA_W-1:0] wbuf_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;

    // -------------------------------------------------------------------------
    // Request legality: direction-specific funct3, natural alignment and the
    // word index falling inside the memory.
    // -------------------------------------------------------------------------
    function automatic logic req_illegal(input logic              we,
                                         input logic [DATA_W-1:0] addr,
                                         input logic [2:0]        f3);
        logic bad_f3;
        logic misaligned;
        logic out_of_range;
        if (we)
            bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
        else
            bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        // f3[1:0] encodes the access size for both signed and unsigned forms
        case (f3[1:0])
            2'b01:   misaligned = addr[0];
            2'b10:   misaligned = (addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        out_of_range = ({2'b00, addr[DATA_W-1:2]} >= DATA_W'(MEM_WORDS));
        return bad_f3 | misaligned | out_of_range;
    endfunction

    // -------------------------------------------------------------------------
    // Load lane selection and extension. Byte k lives at bits 8k+7:8k.
    // -------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] load_extract(input logic [DATA_W-1:0] word,
                                                       input logic [1:0]        lane,
                                                       input logic [2:0]        f3);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic [DATA_W-1:0]  res;
        byte_s = word[{lane, 3'b000} +: 8];
        half_s = word[{lane[1], 4'b0000} +: 16];
        case (f3)
            F3_B:    res = {{(DATA_W-8){byte_s[7]}}, byte_s};
            F3_BU:   res = {{(DATA_W-8){1'b0}}, byte_s};
            F3_H:    res = {{(DATA_W-16){half_s[15]}}, half_s};
            F3_HU:   res = {{(DATA_W-16){1'b0}}, half_s};
            default: res = word;
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Store merge: overwrite only the addressed byte/half of the current word.
    // -------------------------------------------------------------------------
    function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                      input logic [1:0]        lane,
                                                      input logic [2:0]        f3,
                                                      input logic [DATA_W-1:0] wdata);
        logic [DATA_W-1:0] res;
        res = word;
        case (f3)
            F3_B:    res[{lane, 3'b000} +: 8]     = wdata[7:0];
            F3_H:    res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: res = wdata;
        endcase
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Control FSM and registered response. req_* is consumed only in IDLE.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_illegal(req_we, req_addr, req_funct3)) begin
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                            state        <= RESP;
                        end else if (!req_we) begin
                            state <= LOAD;
                        end else if (req_funct3 == F3_W) begin
                            state <= WRITE;
                        end else begin
                            state <= MERGE;
                        end
                    end
                end
                LOAD: begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= load_extract(mem_rdata, addr_q[1:0], funct3_q);
                    state        <= RESP;
                end
                MERGE: begin
                    state <= WRITE;
                end
                WRITE: begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= '0;
                    state        <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Request latch and write buffer (data only, never reset). SW carries the
    // store word straight through; SB/SH overwrite it with the merged word.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            addr_q   <= req_addr;
            funct3_q <= req_funct3;
            wbuf_q   <= req_wdata;
        end else if (state == MERGE) begin
            wbuf_q <= store_merge(mem_rdata, addr_q[1:0], funct3_q, wbuf_q);
        end
    end

    // Memory strobes are decoded from state so reset drops them at once.
    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        mem_we     = (state == WRITE);
        mem_wdata  = (state == WRITE) ? wbuf_q : '0;
        mem_addr   = (state == LOAD || state == MERGE || state == WRITE)
                   ? {2'b00, addr_q[DATA_W-1:2]} : '0;
    end

    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// -----------------------------------------------------------------------------
// tb_dmem_lsu - directed bench for dmem_lsu with a behavioural 32-word memory.
// -----------------------------------------------------------------------------
module tb_dmem_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int tests;
    int fails;

    logic [31:0] mem [32];
    int          we_cnt;
    logic [31:0] last_waddr;

    logic        pre_en;
    logic [4:0]  pre_idx;
    logic [31:0] pre_val;

    dmem_lsu #(.DATA_W(32), .MEM_WORDS(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32) ? mem[mem_addr[4:0]] : 32'h0;

    // Memory model: write commits on the rising edge; pre_en is a bench preload.
    always @(posedge clk) begin
        if (mem_we) begin
            we_cnt     <= we_cnt + 1;
            last_waddr <= mem_addr;
            if (mem_addr < 32)
                mem[mem_addr[4:0]] <= mem_wdata;
        end else if (pre_en) begin
            mem[pre_idx] <= pre_val;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    // Issue one request and check latency, response, and memory write traffic.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input int exp_lat, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_writes);
        int w0;
        int lat;
        bit seen;
        @(negedge clk);
        chk({tag, "/ready_idle"}, {31'b0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wdata;
        req_funct3 = f3;
        w0 = we_cnt;
        @(posedge clk);
        #1;
        // Scramble the request after the accept edge; it must be ignored.
        req_valid  = 1'b0;
        req_we     = ~we;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h0;
        req_funct3 = 3'b111;
        chk({tag, "/ready_busy"}, {31'b0, req_ready}, 32'd0);
        lat  = 0;
        seen = 0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            if (resp_valid) begin
                seen = 1;
                lat  = k;
            end
        end
        chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "/rdata"}, resp_rdata, exp_rdata);
        chk({tag, "/err"}, {31'b0, resp_err}, {31'b0, exp_err});
        @(posedge clk);
        #1;
        chk({tag, "/pulse_end"}, {30'b0, resp_valid, req_ready}, 32'd1);
        chk({tag, "/rdata_hold"}, resp_rdata, exp_rdata);
        chk({tag, "/writes"}, 32'(we_cnt - w0), 32'(exp_writes));
        if (exp_writes > 0)
            chk({tag, "/waddr"}, last_waddr, {2'b00, addr[31:2]});
    endtask

    initial begin
        int w0;
        tests      = 0;
        fails      = 0;
        we_cnt     = 0;
        last_waddr = 32'h0;
        pre_en     = 1'b0;
        pre_idx    = 5'd0;
        pre_val    = 32'h0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_funct3 = 3'b000;

        // Reset state
        #22;
        chk("rst/ready", {31'b0, req_ready}, 32'd1);
        chk("rst/resp", {30'b0, resp_valid, resp_err}, 32'd0);
        chk("rst/rdata", resp_rdata, 32'h0);
        chk("rst/mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst/mem_addr", mem_addr, 32'h0);
        chk("rst/mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        w0 = we_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("idle/no_writes", 32'(we_cnt - w0), 32'd0);

        // SW then LW
        do_req("sw8", 1'b1, 32'h8, 32'hDEADBEEF, 3'b010, 2, 32'h0, 1'b0, 1);
        chk("sw8/mem", mem[2], 32'hDEADBEEF);
        do_req("lw8", 1'b0, 32'h8, 32'h0, 3'b010, 2, 32'hDEADBEEF, 1'b0, 0);

        // SB read-modify-write and byte extension
        preload(5'd2, 32'h11223344);
        do_req("sbA", 1'b1, 32'hA, 32'h123456FF, 3'b000, 3, 32'h0, 1'b0, 1);
        chk("sbA/mem", mem[2], 32'h11FF3344);
        do_req("lbA", 1'b0, 32'hA, 32'h0, 3'b000, 2, 32'hFFFFFFFF, 1'b0, 0);
        do_req("lbuA", 1'b0, 32'hA, 32'h0, 3'b100, 2, 32'h000000FF, 1'b0, 0);
        do_req("lb9", 1'b0, 32'h9, 32'h0, 3'b000, 2, 32'h00000033, 1'b0, 0);

        // SH onto upper half and halfword extension
        preload(5'd3, 32'h0);
        do_req("shE", 1'b1, 32'hE, 32'hABCD8001, 3'b001, 3, 32'h0, 1'b0, 1);
        chk("shE/mem", mem[3], 32'h80010000);
        do_req("lhE", 1'b0, 32'hE, 32'h0, 3'b001, 2, 32'hFFFF8001, 1'b0, 0);
        do_req("lhuE", 1'b0, 32'hE, 32'h0, 3'b101, 2, 32'h00008001, 1'b0, 0);

        // Highest legal word
        preload(5'd31, 32'hCAFE0123);
        do_req("lw7C", 1'b0, 32'h7C, 32'h0, 3'b010, 2, 32'hCAFE0123, 1'b0, 0);

        // Rejected requests: response at T+1, data 0, no memory write
        do_req("e_lw5", 1'b0, 32'h5, 32'h0, 3'b010, 1, 32'h0, 1'b1, 0);
        do_req("e_sh3", 1'b1, 32'h3, 32'h1234, 3'b001, 1, 32'h0, 1'b1, 0);
        do_req("e_lb80", 1'b0, 32'h80, 32'h0, 3'b000, 1, 32'h0, 1'b1, 0);
        do_req("e_f3_011", 1'b0, 32'h0, 32'h0, 3'b011, 1, 32'h0, 1'b1, 0);
        do_req("e_sf3_100", 1'b1, 32'h8, 32'h55, 3'b100, 1, 32'h0, 1'b1, 0);
        chk("err/mem2", mem[2], 32'h11FF3344);
        chk("err/mem3", mem[3], 32'h80010000);

        // Reset during MERGE of an SB
        preload(5'd5, 32'hA5A5A5A5);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h14;
        req_wdata  = 32'h5A;
        req_funct3 = 3'b000;
        w0 = we_cnt;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("mid/in_merge_addr", mem_addr, 32'd5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid/ready", {31'b0, req_ready}, 32'd1);
        chk("mid/mem_we", {31'b0, mem_we}, 32'd0);
        chk("mid/mem_addr", mem_addr, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("mid/no_writes", 32'(we_cnt - w0), 32'd0);
        chk("mid/mem5", mem[5], 32'hA5A5A5A5);
        do_req("post_lw14", 1'b0, 32'h14, 32'h0, 3'b010, 2, 32'hA5A5A5A5, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
